// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the core's fetch (i_*) and data (d_*) requests onto
// one memory bus (m_*), allowing one outstanding transaction at a time.
// Data requests win arbitration. After STARVE_LIMIT consecutive data grants made
// while a fetch is waiting, the fetch wins the next arbitration.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_valid/i_addr             fetch request (held until i_data_ok)
//   i_addr_ok/i_data_ok/i_data fetch accept pulse, data pulse, instruction word
//   d_valid/d_addr/d_size/d_strobe/d_wdata  data request (held until d_data_ok)
//   d_addr_ok/d_data_ok/d_rdata data accept pulse, completion pulse, read data
//   m_valid/m_is_write/m_addr/m_size/m_strobe/m_wdata  memory request
//   m_ready                    memory accepts the request
//   m_resp_valid/m_rdata       memory response
module core_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic        m_is_write,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_resp_valid,
  input  logic [63:0] m_rdata
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 3;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(15);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_d_q, gnt_d_d;
  logic            abandon_q, abandon_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_write_q, is_write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SW-1:0]   size_q, size_d;
  logic [BW-1:0]   strobe_q, strobe_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic pick_d, pick_i, gvalid;

  // Arbitration: data first unless the fetch side has been starved.
  assign pick_d = (state_q == ST_IDLE) && d_valid &&
                  (!i_valid || (cnt_q < CW'(STARVE_LIMIT)));
  assign pick_i = (state_q == ST_IDLE) && !pick_d && i_valid;
  assign gvalid = gnt_d_q ? d_valid : i_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_d || pick_i) state_d = ST_REQ;
      ST_REQ:  if (m_ready)          state_d = ST_WAIT;
      ST_WAIT: if (m_resp_valid)     state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Request capture, starvation counter and abandon tracking
  always_comb begin
    gnt_d_d    = gnt_d_q;
    abandon_d  = abandon_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    if (state_q == ST_IDLE) begin
      if (!i_valid) cnt_d = '0;
      if (pick_d) begin
        gnt_d_d    = 1'b1;
        abandon_d  = 1'b0;
        is_write_d = |d_strobe;
        addr_d     = d_addr;
        size_d     = d_size;
        strobe_d   = d_strobe;
        wdata_d    = d_wdata;
        if (i_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
      end else if (pick_i) begin
        gnt_d_d    = 1'b0;
        abandon_d  = 1'b0;
        is_write_d = 1'b0;
        addr_d     = i_addr;
        size_d     = SW'(2);
        strobe_d   = '0;
        wdata_d    = '0;
        cnt_d      = '0;
      end
    end else if (!gvalid) begin
      // Once the owner lets go, its response is dropped even if it re-requests.
      abandon_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_d_q    <= 1'b0;
      abandon_q  <= 1'b0;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
    end else begin
      gnt_d_q    <= gnt_d_d;
      abandon_q  <= abandon_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
    end
  end

  // Output logic; d_* paths only look at d_valid, i_* paths only at i_valid.
  always_comb begin
    i_addr_ok  = 1'b0;
    i_data_ok  = 1'b0;
    i_data     = '0;
    d_addr_ok  = 1'b0;
    d_data_ok  = 1'b0;
    d_rdata    = '0;
    m_valid    = 1'b0;
    m_is_write = 1'b0;
    m_addr     = '0;
    m_size     = '0;
    m_strobe   = '0;
    m_wdata    = '0;
    case (state_q)
      ST_REQ: begin
        m_valid    = 1'b1;
        m_is_write = is_write_q;
        m_addr     = addr_q;
        m_size     = size_q;
        m_strobe   = strobe_q;
        m_wdata    = wdata_q;
        if (m_ready) begin
          i_addr_ok = !gnt_d_q;
          d_addr_ok = gnt_d_q;
        end
      end
      ST_WAIT: begin
        if (m_resp_valid && !abandon_q) begin
          if (gnt_d_q) begin
            if (d_valid) begin
              d_data_ok = 1'b1;
              d_rdata   = m_rdata;
            end
          end else if (i_valid) begin
            i_data_ok = 1'b1;
            i_data    = addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of the pipelined core's instruction and data bus ports.
- Merges the fetch request (ibus) and the memory-stage request (dbus) onto the single memory-side bus that the core shares.
- Allows one outstanding transaction at a time. Data requests have priority, with a starvation guard so fetch still makes progress.
- Returns the response only to the master that was granted.

Parameters:
- STARVE_LIMIT, 4: number of consecutive dbus grants taken while ibus is waiting, after which ibus wins the next arbitration. Range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- i_valid  in  1  fetch request valid; held until i_data_ok
- i_addr  in  64  fetch address; 4-byte aligned
- i_addr_ok  out  1  fetch request accepted (pulse)
- i_data_ok  out  1  fetch data returned (pulse)
- i_data  out  32  instruction word
- d_valid  in  1  data request valid; held until d_data_ok
- d_addr  in  64  data address
- d_size  in  3  log2 of access bytes (0..3)
- d_strobe  in  8  byte write enables; 0 means read
- d_wdata  in  64  write data
- d_addr_ok  out  1  data request accepted (pulse)
- d_data_ok  out  1  data access complete (pulse)
- d_rdata  out  64  read data
- m_valid  out  1  memory request valid
- m_is_write  out  1  memory request is a write
- m_addr  out  64  memory address
- m_size  out  3  memory access size
- m_strobe  out  8  memory byte enables
- m_wdata  out  64  memory write data
- m_ready  in  1  memory accepts the request this cycle
- m_resp_valid  in  1  memory response valid
- m_rdata  in  64  memory read data

Behaviour:
- States are IDLE, REQ and WAIT. On reset: state is IDLE, starvation counter is 0, and every output is 0.
- IDLE, arbitration:
  - If d_valid and (!i_valid or counter < STARVE_LIMIT), grant D. Otherwise, if i_valid, grant I.
  - On grant, latch the granted master's fields into the request registers and move to REQ on the next edge.
  - For I grants: m_size = 2, m_strobe = 0, m_is_write = 0.
  - For D grants: m_is_write = |d_strobe.
  - If neither master is valid, stay in IDLE.
- Starvation counter:
  - Increments, saturating at 15, on each D grant made while i_valid = 1.
  - Clears on any I grant, and in any IDLE cycle where i_valid = 0.
- REQ:
  - m_valid = 1 and all m_* outputs come from the registers.
  - Outputs must be held stable until m_ready.
  - When m_ready = 1: pulse the granted master's *_addr_ok in that cycle, then go to WAIT.
- WAIT:
  - m_valid = 0.
  - When m_resp_valid = 1, the granted master's *_data_ok = 1 combinationally in that same cycle. State returns to IDLE on the next edge.
  - d_rdata = m_rdata.
  - i_data = m_rdata[63:32] if latched addr[2] = 1, else m_rdata[31:0].
  - i_data and d_rdata are 0 whenever the corresponding data_ok is 0.
- Minimum latency: request seen in IDLE at cycle 0; m_valid at cycle 1; if m_ready in cycle 1, a response can arrive in cycle 2, with data_ok in cycle 2. Back-to-back transactions re-arbitrate in the IDLE cycle that follows.
- Master abandon: if the granted master deasserts valid (for example a pipeline flush) before completion:
  - The memory transaction still completes; a write stays a write.
  - The *_data_ok for that transaction is suppressed.
  - The state machine still returns to IDLE normally.
- Other rules:
  - m_resp_valid received outside WAIT is ignored.
  - m_ready received outside REQ is ignored.
  - No response ever goes to the non-granted master.
  - Reset asserted in any state returns immediately (asynchronously) to IDLE with all outputs 0. An in-flight response arriving after reset is ignored.
  - Both masters valid in the same IDLE cycle is resolved only by the arbitration rule above; there is no combinational path from i_valid to the d_* outputs.

Test Plan:
- Fetch only: i_valid = 1, i_addr = 0x8000_0004, m_ready in cycle 1, m_resp_valid in cycle 2 with m_rdata = 0x1111_2222_3333_4444 -> m_addr = 0x8000_0004, m_size = 2, i_addr_ok in cycle 1, i_data_ok in cycle 2 with i_data = 0x1111_2222.
- Store: d_valid with d_addr = 0x8000_1000, d_strobe = 0x0F, d_wdata = 0xDEAD_BEEF -> m_is_write = 1 and m_strobe = 0x0F held for 3 cycles of m_ready = 0; d_data_ok only when m_resp_valid arrives.
- Contention: i_valid and d_valid both held high with STARVE_LIMIT = 4 and 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I,...
- Abandon: d_valid dropped during WAIT -> m_resp_valid produces no d_data_ok; the next i_valid is granted from IDLE.
- Reset mid-WAIT: reset pulsed, then m_resp_valid = 1 -> no data_ok, m_valid = 0, and the next request proceeds from IDLE.
- Spurious response: m_resp_valid = 1 while in IDLE -> no data_ok on either master and no state change.
